gf180mcu_fd_sc_mcu9t5v0__dffn_pipe: RTL and testbench
=====================================================

// Module: gf180mcu_fd_sc_mcu9t5v0__dffn_pipe
// PURPOSE
//  Parametrised successor to the single-bit negative-edge set flop. WIDTH-bit data,
//  DEPTH-stage register pipeline, all updates on the falling edge of CLKN.
//  Each stage carries a valid bit. Stages shift together under EN.
//  Provides stage stall, flush and a live occupancy counter.
//  Sits between MCU9T datapath blocks that retime multi-bit buses on the inverted clock.
//  Synchronous reset loads a per-bit INIT_VAL, which generalises the fixed set-to-1 behaviour.
// PARAMETERS
//  WIDTH         8          data bits per stage (>=1)
//  DEPTH         2          pipeline stages (>=1); latency in enabled CLKN falling edges
//  INIT_VAL      {WIDTH{1}} value loaded into every stage's data on reset (per-bit set/clear)
//  GATE_INVALID  0          1: a stage's data loads only when its source valid=1; 0: data always shifts
// PORTS
//  CLKN   in   1             clock; all state updates on negedge CLKN
//  RST    in   1             synchronous reset, active-high, sampled on negedge CLKN
//  EN     in   1             shift enable; 0 = stall (all state holds)
//  FLUSH  in   1             synchronous clear of all valid bits
//  D      in   WIDTH         input data
//  DV     in   1             input data valid
//  Q      out  WIDTH         data of last stage (stage DEPTH-1)
//  QV     out  1             valid of last stage
//  OCC    out  CW            count of valid stages, 0..DEPTH; CW=$clog2(DEPTH+1)
// BEHAVIOUR
//  - Storage: dat[0..DEPTH-1] (WIDTH each), vld[0..DEPTH-1], occ (CW).
//  - Outputs are registered, with no combinational path from inputs: Q=dat[DEPTH-1], QV=vld[DEPTH-1], OCC=occ.
//  - Priority on each negedge CLKN: RST > FLUSH > EN > hold.
//  - RST=1:
//    - every dat[i] <= INIT_VAL, vld[i] <= 0, occ <= 0.
//    - Reset values are therefore Q=INIT_VAL, QV=0, OCC=0.
//    - Before the first reset edge, outputs are X; no asynchronous path exists.
//  - FLUSH=1 (RST=0):
//    - all vld <= 0, occ <= 0. dat is unchanged.
//    - FLUSH overrides EN; the D/DV presented on that edge is discarded.
//  - EN=1 (RST=0, FLUSH=0): shift by one stage.
//    - vld[0] <= DV; vld[i] <= vld[i-1] for i>=1.
//    - GATE_INVALID=0: dat[0] <= D; dat[i] <= dat[i-1].
//    - GATE_INVALID=1: dat[0] <= D only if DV=1; dat[i] <= dat[i-1] only if vld[i-1]=1; otherwise the stage holds its data.
//    - occ <= occ + DV - vld[DEPTH-1].
//    - Simultaneous DV=1 with vld[DEPTH-1]=1 leaves occ unchanged.
//    - occ never exceeds DEPTH and never underflows (by construction).
//  - EN=0 (RST=0, FLUSH=0): all state holds. D and DV are ignored and no data is lost.
//  - Latency: a word presented with DV=1 appears on Q with QV=1 after exactly DEPTH enabled negedges.
//    - Stalled edges add no progress.
//  - Invariant: OCC equals popcount(vld) at all times. Verification asserts this every cycle.
//  - DEPTH=1: a single register; OCC is 1 bit and equals QV.
//  - Rising edge of CLKN has no effect on any state.
//  - Reset asserted mid-stream discards all in-flight words on that same edge.
//    - The first edge after RST deasserts behaves as a normal EN/FLUSH edge.
// TESTING
//  Every step below is a negedge CLKN; defaults WIDTH=8, DEPTH=2 unless stated.
//  T1 reset: RST=1 for 1 edge with INIT_VAL=8'hA5 -> Q=8'hA5, QV=0, OCC=0.
//     Then RST=0, EN=0 for 3 edges -> all outputs unchanged.
//  T2 latency: EN=1; D=8'h11,DV=1 then D=8'h22,DV=1 then DV=0.
//     -> Q=8'h11,QV=1 after edge 2; Q=8'h22 after edge 3; QV=0 after edge 4.
//     -> OCC sequence 1,2,1,0.
//  T3 stall: stream 8'h33,8'h44 with EN=0 held 3 edges between them.
//     -> Q/QV/OCC frozen during the stall; both words emerge intact and in order.
//  T4 flush vs enable: pipeline full (OCC=2), FLUSH=1, EN=1, DV=1, D=8'h55 on one edge.
//     -> QV=0, OCC=0, Q keeps its prior data; 8'h55 never appears with QV=1.
//  T5 gating: GATE_INVALID=1, DEPTH=3; send 8'h66 valid, then DV=0 with D=8'hFF for 4 edges.
//     -> Q shows 8'h66 with QV=1 once, then stays 8'h66 with QV=0; 8'hFF never reaches Q.
//  T6 reset mid-stream: OCC=2, RST=1 and FLUSH=1 on the same edge as DV=1.
//     -> Q=INIT_VAL, QV=0, OCC=0. Random-stress run checks OCC==popcount(vld) throughout.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dffn_pipe.sv
// ============================================================================
// gf180mcu_fd_sc_mcu9t5v0__dffn_pipe
// Falling-edge WIDTH x DEPTH register pipeline with valid, stall, flush, OCC.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module gf180mcu_fd_sc_mcu9t5v0__dffn_pipe #(
    parameter int               WIDTH        = 8,
    parameter int               DEPTH        = 2,
    parameter logic [WIDTH-1:0] INIT_VAL     = {WIDTH{1'b1}},
    parameter bit               GATE_INVALID = 1'b0
) (
    input  logic                         CLKN,
    input  logic                         RST,
    input  logic                         EN,
    input  logic                         FLUSH,
    input  logic [WIDTH-1:0]             D,
    input  logic                         DV,
    output logic [WIDTH-1:0]             Q,
    output logic                         QV,
    output logic [$clog2(DEPTH+1)-1:0]   OCC
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] dat_q [DEPTH];
    logic [WIDTH-1:0] dat_d [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [CW-1:0]    occ_q;
    logic [CW-1:0]    occ_d;

    // Flush only clears valid bits; the data registers keep their contents.
    always_comb begin
        dat_d = dat_q;
        vld_d = vld_q;
        occ_d = occ_q;
        if (FLUSH) begin
            vld_d = '0;
            occ_d = '0;
        end else if (EN) begin
            vld_d[0] = DV;
            if (!GATE_INVALID || DV) begin
                dat_d[0] = D;
            end
            for (int i = 1; i < DEPTH; i++) begin
                vld_d[i] = vld_q[i-1];
                if (!GATE_INVALID || vld_q[i-1]) begin
                    dat_d[i] = dat_q[i-1];
                end
            end
            occ_d = occ_q + CW'(DV) - CW'(vld_q[DEPTH-1]);
        end
    end

    always_ff @(negedge CLKN) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                dat_q[i] <= INIT_VAL;
            end
            vld_q <= '0;
            occ_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                dat_q[i] <= dat_d[i];
            end
            vld_q <= vld_d;
            occ_q <= occ_d;
        end
    end

    assign Q   = dat_q[DEPTH-1];
    assign QV  = vld_q[DEPTH-1];
    assign OCC = occ_q;

endmodule

`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__dffn_pipe.sv
// ============================================================================
// tb_gf180mcu_fd_sc_mcu9t5v0__dffn_pipe
// Scoreboard bench: three pipeline configurations against a history-based model.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gf180mcu_fd_sc_mcu9t5v0__dffn_pipe;

    typedef struct {
        logic [7:0] q;
        logic       qv;
        int         occ;
    } exp_t;

    logic       clkn = 1'b1;
    logic       rst  = 1'b0;
    logic       en   = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] d    = 8'h00;
    logic       dv   = 1'b0;

    logic [7:0] q0, q1, q2;
    logic       qv0, qv1, qv2;
    logic [1:0] occ0, occ1;
    logic       occ2;

    int total = 0;
    int bad   = 0;

    exp_t eq0[$];
    exp_t eq1[$];
    exp_t eq2[$];

    // Model: the last DEPTH enabled-edge input slots, newest at index 0, plus
    // the most recent word that arrived at the output while valid.
    logic [7:0] hd [3][3];
    bit         hv [3][3];
    logic [7:0] last_valid [3];

    always #5 clkn = ~clkn;

    gf180mcu_fd_sc_mcu9t5v0__dffn_pipe #(
        .WIDTH(8), .DEPTH(2), .INIT_VAL(8'hA5), .GATE_INVALID(1'b0)
    ) u0 (
        .CLKN(clkn), .RST(rst), .EN(en), .FLUSH(flush), .D(d), .DV(dv),
        .Q(q0), .QV(qv0), .OCC(occ0)
    );

    gf180mcu_fd_sc_mcu9t5v0__dffn_pipe #(
        .WIDTH(8), .DEPTH(3), .INIT_VAL(8'h3C), .GATE_INVALID(1'b1)
    ) u1 (
        .CLKN(clkn), .RST(rst), .EN(en), .FLUSH(flush), .D(d), .DV(dv),
        .Q(q1), .QV(qv1), .OCC(occ1)
    );

    gf180mcu_fd_sc_mcu9t5v0__dffn_pipe #(
        .WIDTH(8), .DEPTH(1), .GATE_INVALID(1'b0)
    ) u2 (
        .CLKN(clkn), .RST(rst), .EN(en), .FLUSH(flush), .D(d), .DV(dv),
        .Q(q2), .QV(qv2), .OCC(occ2)
    );

    task automatic model_step(input int k, input int depth, input bit gate,
                              input logic [7:0] init, input bit r, input bit f,
                              input bit e, input logic [7:0] dd, input bit v,
                              output exp_t ex);
        int n;
        if (r) begin
            for (int i = 0; i < depth; i++) begin
                hd[k][i] = init;
                hv[k][i] = 1'b0;
            end
            last_valid[k] = init;
        end else if (f) begin
            for (int i = 0; i < depth; i++) hv[k][i] = 1'b0;
        end else if (e) begin
            for (int i = depth - 1; i > 0; i--) begin
                hd[k][i] = hd[k][i-1];
                hv[k][i] = hv[k][i-1];
            end
            hd[k][0] = dd;
            hv[k][0] = v;
            if (hv[k][depth-1]) last_valid[k] = hd[k][depth-1];
        end
        n = 0;
        for (int i = 0; i < depth; i++) n += int'(hv[k][i]);
        ex.q   = gate ? last_valid[k] : hd[k][depth-1];
        ex.qv  = hv[k][depth-1];
        ex.occ = n;
    endtask

    task automatic step(input bit r, input bit f, input bit e,
                        input logic [7:0] dd, input bit v);
        exp_t ex;
        @(posedge clkn);
        #1;
        rst = r; flush = f; en = e; d = dd; dv = v;
        model_step(0, 2, 1'b0, 8'hA5, r, f, e, dd, v, ex); eq0.push_back(ex);
        model_step(1, 3, 1'b1, 8'h3C, r, f, e, dd, v, ex); eq1.push_back(ex);
        model_step(2, 1, 1'b0, 8'hFF, r, f, e, dd, v, ex); eq2.push_back(ex);
    endtask

    task automatic check(input int k, input logic [7:0] aq, input logic aqv,
                         input int aocc, input exp_t ex);
        total += 3;
        if (aq !== ex.q) begin
            bad++;
            $display("FAIL dut%0d Q got=%h want=%h at %0t", k, aq, ex.q, $time);
        end
        if (aqv !== ex.qv) begin
            bad++;
            $display("FAIL dut%0d QV got=%b want=%b at %0t", k, aqv, ex.qv, $time);
        end
        if (aocc != ex.occ) begin
            bad++;
            $display("FAIL dut%0d OCC got=%0d want=%0d at %0t", k, aocc, ex.occ, $time);
        end
    endtask

    // Monitor: outputs settle after each falling edge; compare one entry per edge.
    initial begin
        forever begin
            @(negedge clkn);
            #2;
            if (eq0.size() > 0) check(0, q0, qv0, int'(occ0), eq0.pop_front());
            if (eq1.size() > 0) check(1, q1, qv1, int'(occ1), eq1.pop_front());
            if (eq2.size() > 0) check(2, q2, qv2, int'(occ2), eq2.pop_front());
        end
    end

    initial begin
        // reset, then idle stall
        step(1, 0, 0, 8'h00, 0);
        repeat (3) step(0, 0, 0, 8'hDE, 1);
        // latency
        step(0, 0, 1, 8'h11, 1);
        step(0, 0, 1, 8'h22, 1);
        step(0, 0, 1, 8'h00, 0);
        step(0, 0, 1, 8'h00, 0);
        // stall between two words
        step(0, 0, 1, 8'h33, 1);
        repeat (3) step(0, 0, 0, 8'hEE, 1);
        step(0, 0, 1, 8'h44, 1);
        repeat (3) step(0, 0, 1, 8'h00, 0);
        // flush beats enable with a full pipeline
        step(0, 0, 1, 8'h01, 1);
        step(0, 0, 1, 8'h02, 1);
        step(0, 0, 1, 8'h03, 1);
        step(0, 1, 1, 8'h55, 1);
        repeat (3) step(0, 0, 1, 8'h00, 0);
        // gating: one valid word followed by invalid junk
        step(0, 0, 1, 8'h66, 1);
        repeat (4) step(0, 0, 1, 8'hFF, 0);
        // reset mid-stream with flush and valid input on the same edge
        step(0, 0, 1, 8'h77, 1);
        step(0, 0, 1, 8'h88, 1);
        step(1, 1, 1, 8'h99, 1);
        step(0, 0, 1, 8'hAB, 1);
        // random stress
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom));
        end
        step(0, 0, 0, 8'h00, 0);
        repeat (3) @(posedge clkn);
        total++;
        if (eq0.size() + eq1.size() + eq2.size() != 0) begin
            bad++;
            $display("FAIL drain pending got=%0d want=0",
                     eq0.size() + eq1.size() + eq2.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
